// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   word_t           32-bit machine word
//   fetch_state_t    fetch FSM states (BOOT / ISSUE / HOLD)
//   MIPS_NOP         canonical NOP encoding (sll $0,$0,0)
//   DEFAULT_RESET_PC default PC after reset
//   align_word()     forces a byte address onto a word boundary
package mips_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_ISSUE = 2'd1,
        FETCH_HOLD  = 2'd2
    } fetch_state_t;

    localparam word_t MIPS_NOP         = 32'h0000_0000;
    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus.
//   req    fetch request (fetch -> memory)
//   addr   word address of the fetch (fetch -> memory)
//   ack    rdata holds the requested instruction (memory -> fetch)
//   rdata  instruction word (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid register for a fetched instruction that could not enter
// IF/ID because the pipeline was stalled when the memory acknowledged.
//   clk, rst_n            clock, asynchronous active-low reset
//   load                  capture {load_pc, load_instr}
//   drain                 entry consumed, buffer becomes empty
//   clear                 discard the entry (flush); wins over load/drain
//   valid, buf_pc, buf_instr   stored entry
module fetch_hold_buf
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  word_t load_pc,
    input  word_t load_instr,
    output logic  valid,
    output word_t buf_pc,
    output word_t buf_instr
);

    logic  valid_reg;
    word_t pc_reg;
    word_t instr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid     = valid_reg;
    assign buf_pc    = pc_reg;
    assign buf_instr = instr_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ack handshake and the
// IF/ID pipeline register, controlled by the hazard unit (stall) and the
// branch unit (redirect).
//   clk, rst_n     clock, asynchronous active-low reset
//   next_pc        selected next PC from the PC mux (bits [1:0] ignored)
//   redirect       taken branch/jump: flushes the stage, loads next_pc
//   stall          hold IF/ID and freeze the PC
//   pc_out         current PC
//   imem           fetch_stage_if master: req/addr out, ack/rdata in
//   ifid_valid/pc/pc4/instr   IF/ID register (instr = NOP_INSTR on bubble)
// Optional feature macro FETCH_PERF_EN adds wrapping counters
//   perf_fetched (instructions written into IF/ID) and
//   perf_stall (cycles with stall=1 or an unacknowledged request).
module fetch_stage
    import mips_pkg::*;
#(
    parameter word_t RESET_PC  = DEFAULT_RESET_PC,
    parameter word_t NOP_INSTR = MIPS_NOP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  word_t         next_pc,
    input  logic          redirect,
    input  logic          stall,
    output word_t         pc_out,
    fetch_stage_if.master imem,
    output logic          ifid_valid,
    output word_t         ifid_pc,
    output word_t         ifid_pc4,
    output word_t         ifid_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    fetch_state_t state_reg, state_next;
    word_t        pc_reg, pc_next;
    logic         ifid_valid_reg, ifid_valid_next;
    word_t        ifid_pc_reg, ifid_pc_next;
    word_t        ifid_pc4_reg, ifid_pc4_next;
    word_t        ifid_instr_reg, ifid_instr_next;

    logic         buf_load, buf_drain, buf_clear;
    logic         buf_valid;
    word_t        buf_pc, buf_instr;

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .drain      (buf_drain),
        .clear      (buf_clear),
        .load_pc    (pc_reg),
        .load_instr (imem.rdata),
        .valid      (buf_valid),
        .buf_pc     (buf_pc),
        .buf_instr  (buf_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FETCH_BOOT;
            pc_reg         <= RESET_PC;
            ifid_valid_reg <= 1'b0;
            ifid_pc_reg    <= '0;
            ifid_pc4_reg   <= '0;
            ifid_instr_reg <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ifid_valid_reg <= ifid_valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            ifid_instr_reg <= ifid_instr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_pc4_next   = ifid_pc4_reg;
        ifid_instr_next = ifid_instr_reg;
        buf_load        = 1'b0;
        buf_drain       = 1'b0;
        buf_clear       = 1'b0;

        if (redirect) begin
            // Flush beats stall and ack; any data arriving this cycle
            // belongs to the wrong path and is dropped.
            pc_next         = align_word(next_pc);
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
            buf_clear       = 1'b1;
            state_next      = FETCH_ISSUE;
        end else begin
            unique case (state_reg)
                FETCH_BOOT: begin
                    state_next = FETCH_ISSUE;
                end
                FETCH_ISSUE: begin
                    if (imem.ack && !stall) begin
                        ifid_valid_next = 1'b1;
                        ifid_pc_next    = pc_reg;
                        ifid_pc4_next   = pc_reg + 32'd4;
                        ifid_instr_next = imem.rdata;
                        pc_next         = align_word(next_pc);
                    end else if (imem.ack) begin
                        // Data arrived while decode is stalled: park it so
                        // the memory is never asked twice for one word.
                        buf_load   = 1'b1;
                        state_next = FETCH_HOLD;
                    end else if (!stall) begin
                        ifid_valid_next = 1'b0;
                        ifid_instr_next = NOP_INSTR;
                    end
                end
                FETCH_HOLD: begin
                    if (!stall && buf_valid) begin
                        ifid_valid_next = 1'b1;
                        ifid_pc_next    = buf_pc;
                        ifid_pc4_next   = buf_pc + 32'd4;
                        ifid_instr_next = buf_instr;
                        buf_drain       = 1'b1;
                        pc_next         = align_word(next_pc);
                        state_next      = FETCH_ISSUE;
                    end
                end
                default: begin
                    state_next = FETCH_BOOT;
                end
            endcase
        end
    end

    assign pc_out     = pc_reg;
    assign imem.req   = (state_reg == FETCH_ISSUE);
    assign imem.addr  = pc_reg;
    assign ifid_valid = ifid_valid_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_pc4   = ifid_pc4_reg;
    assign ifid_instr = ifid_instr_reg;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;
    logic        fetched_now;
    logic        stalled_now;

    assign fetched_now = !redirect && !stall &&
                         ((state_reg == FETCH_ISSUE && imem.ack) ||
                          (state_reg == FETCH_HOLD && buf_valid));
    assign stalled_now = stall || (state_reg == FETCH_ISSUE && !imem.ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (fetched_now) perf_fetched_reg <= perf_fetched_reg + 32'd1;
            if (stalled_now) perf_stall_reg   <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import mips_pkg::*;

    localparam word_t TB_RESET_PC = 32'h0000_0000;
    localparam word_t TB_NOP      = 32'h0000_0000;

    localparam int M_BOOT  = 0;
    localparam int M_ISSUE = 1;
    localparam int M_HOLD  = 2;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst_n;
    word_t next_pc;
    logic  redirect;
    logic  stall;
    word_t pc_out;
    logic  ifid_valid;
    word_t ifid_pc;
    word_t ifid_pc4;
    word_t ifid_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(TB_RESET_PC), .NOP_INSTR(TB_NOP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .stall      (stall),
        .pc_out     (pc_out),
        .imem       (bus.master),
        .ifid_valid (ifid_valid),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_instr (ifid_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;

    // Reference model: the architectural state the stage should expose.
    int    m_state;
    word_t m_pc;
    bit    m_valid;
    word_t m_ipc, m_ipc4, m_instr;
    word_t hold_q_pc[$];
    word_t hold_q_instr[$];
    int unsigned m_fetched, m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_BOOT;
        m_pc    = TB_RESET_PC;
        m_valid = 1'b0;
        m_ipc   = '0;
        m_ipc4  = '0;
        m_instr = TB_NOP;
        hold_q_pc.delete();
        hold_q_instr.delete();
        m_fetched = 0;
        m_stalls  = 0;
    endtask

    task automatic compare_model();
        chk("pc_out", pc_out, m_pc);
        chk("imem_req", {31'b0, bus.req}, {31'b0, (m_state == M_ISSUE)});
        if (m_state == M_ISSUE) chk("imem_addr", bus.addr, m_pc);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("ifid_pc", ifid_pc, m_ipc);
            chk("ifid_pc4", ifid_pc4, m_ipc4);
        end
        chk("ifid_instr", ifid_instr, m_valid ? m_instr : TB_NOP);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stalls);
`endif
    endtask

    // One clock: drive inputs, advance the model by the stage rules,
    // then compare after the edge.
    task automatic step(input logic s, input logic r, input logic a,
                        input word_t rd, input word_t np);
        stall     = s;
        redirect  = r;
        bus.ack   = a;
        bus.rdata = rd;
        next_pc   = np;

        if (s || (m_state == M_ISSUE && !a)) m_stalls++;
        if (r) begin
            m_pc    = np & ~32'd3;
            m_valid = 1'b0;
            m_instr = TB_NOP;
            hold_q_pc.delete();
            hold_q_instr.delete();
            m_state = M_ISSUE;
        end else if (m_state == M_BOOT) begin
            m_state = M_ISSUE;
        end else if (m_state == M_ISSUE) begin
            if (a && !s) begin
                m_valid = 1'b1;
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 4;
                m_instr = rd;
                m_pc    = np & ~32'd3;
                m_fetched++;
            end else if (a) begin
                hold_q_pc.push_back(m_pc);
                hold_q_instr.push_back(rd);
                m_state = M_HOLD;
            end else if (!s) begin
                m_valid = 1'b0;
                m_instr = TB_NOP;
            end
        end else begin
            if (!s) begin
                m_valid = 1'b1;
                m_ipc   = hold_q_pc.pop_front();
                m_ipc4  = m_ipc + 4;
                m_instr = hold_q_instr.pop_front();
                m_pc    = np & ~32'd3;
                m_state = M_ISSUE;
                m_fetched++;
            end
        end

        @(posedge clk);
        #1;
        n_step++;
        $display("step %0d s=%0b r=%0b a=%0b np=%h | pc=%h req=%0b v=%0b ipc=%h instr=%h",
                 n_step, s, r, a, np, pc_out, bus.req, ifid_valid, ifid_pc, ifid_instr);
        compare_model();
    endtask

    typedef struct {
        logic  s, r, a;
        word_t rd, np;
        logic  e_req;
        word_t e_pc;
        logic  e_valid;
        word_t e_ipc, e_instr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        next_pc   = '0;
        bus.ack   = 1'b0;
        bus.rdata = '0;
        model_reset();

        // Reset state
        #2;
        chk("rst_req", {31'b0, bus.req}, 32'd0);
        chk("rst_pc", pc_out, TB_RESET_PC);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_ifid_pc", ifid_pc, 32'd0);
        chk("rst_ifid_pc4", ifid_pc4, 32'd0);
        chk("rst_instr", ifid_instr, TB_NOP);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //        s  r  a  rdata          np            req pc_out        v  ifid_pc       instr
        tbl[0] = '{0, 0, 0, 32'h0,         32'h4,        1, 32'h0,        0, 32'h0,        TB_NOP};
        tbl[1] = '{0, 0, 1, 32'h1111_0000, 32'h4,        1, 32'h4,        1, 32'h0,        32'h1111_0000};
        tbl[2] = '{0, 0, 1, 32'h1111_0001, 32'h8,        1, 32'h8,        1, 32'h4,        32'h1111_0001};
        tbl[3] = '{0, 0, 0, 32'h0,         32'hC,        1, 32'h8,        0, 32'h0,        TB_NOP};
        tbl[4] = '{1, 0, 1, 32'h1111_0002, 32'hC,        0, 32'h8,        0, 32'h0,        TB_NOP};
        tbl[5] = '{1, 0, 0, 32'h0,         32'hC,        0, 32'h8,        0, 32'h0,        TB_NOP};
        tbl[6] = '{0, 0, 0, 32'h0,         32'hC,        1, 32'hC,        1, 32'h8,        32'h1111_0002};
        tbl[7] = '{0, 1, 1, 32'h1111_0003, 32'h203,      1, 32'h200,      0, 32'h0,        TB_NOP};
        tbl[8] = '{0, 0, 1, 32'h1111_0004, 32'h204,      1, 32'h204,      1, 32'h200,      32'h1111_0004};
        tbl[9] = '{1, 0, 0, 32'h0,         32'h208,      1, 32'h204,      1, 32'h200,      32'h1111_0004};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].a, tbl[i].rd, tbl[i].np);
            chk($sformatf("tbl%0d_req", i), {31'b0, bus.req}, {31'b0, tbl[i].e_req});
            chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].e_pc);
            chk($sformatf("tbl%0d_valid", i), {31'b0, ifid_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_ifid_pc", i), ifid_pc, tbl[i].e_ipc);
                chk($sformatf("tbl%0d_ifid_pc4", i), ifid_pc4, tbl[i].e_ipc + 32'd4);
            end
            chk($sformatf("tbl%0d_instr", i), ifid_instr, tbl[i].e_instr);
        end

        // Wait-state memory: ack three cycles after the request at 0x40
        step(0, 1, 0, 32'h0, 32'h40);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 32'h0, 32'h44);
            chk("wait_req", {31'b0, bus.req}, 32'd1);
            chk("wait_addr", bus.addr, 32'h40);
            chk("wait_valid", {31'b0, ifid_valid}, 32'd0);
        end
        step(0, 0, 1, 32'h2222_0040, 32'h44);
        chk("wait_ifid_pc", ifid_pc, 32'h40);
        chk("wait_instr", ifid_instr, 32'h2222_0040);
        chk("wait_next_addr", bus.addr, 32'h44);

        // Redirect in the same cycle as the ack of 0x10
        step(0, 1, 0, 32'h0, 32'h10);
        step(0, 1, 1, 32'h3333_0010, 32'h200);
        chk("redir_valid", {31'b0, ifid_valid}, 32'd0);
        chk("redir_addr", bus.addr, 32'h200);
        step(0, 0, 0, 32'h0, 32'h204);
        chk("redir_valid2", {31'b0, ifid_valid}, 32'd0);
        chk("redir_req", {31'b0, bus.req}, 32'd1);

        // PC wrap at the top of the address space
        step(0, 1, 0, 32'h0, 32'hFFFF_FFFC);
        step(0, 0, 1, 32'h4444_FFFC, 32'h0);
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_ifid_pc4", ifid_pc4, 32'h0);
        chk("wrap_addr", bus.addr, 32'h0);

        // Four-cycle stall with ack: entry parked, request dropped
        step(1, 0, 1, 32'h5555_0000, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 32'h0, 32'h4);
            chk("hold_req", {31'b0, bus.req}, 32'd0);
            chk("hold_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        end
        step(0, 0, 0, 32'h0, 32'h4);
        chk("drain_ifid_pc", ifid_pc, 32'h0);
        chk("drain_instr", ifid_instr, 32'h5555_0000);
        chk("drain_addr", bus.addr, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic  s, r, a;
            word_t np;
            s  = ($urandom_range(3) == 0);
            r  = ($urandom_range(9) == 0);
            a  = (m_state == M_ISSUE) && ($urandom_range(1) == 1);
            np = r ? $urandom : ((m_pc + 32'd4) | word_t'($urandom_range(3)));
            step(s, r, a, $urandom, np);
        end

        // Reset mid-wait at 0x80
        step(0, 1, 0, 32'h0, 32'h80);
        step(0, 0, 0, 32'h0, 32'h84);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, bus.req}, 32'd0);
        chk("midrst_pc", pc_out, TB_RESET_PC);
        chk("midrst_valid", {31'b0, ifid_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("midrst_perf_fetched", perf_fetched, 32'd0);
        chk("midrst_perf_stall", perf_stall, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, (m_state == M_ISSUE), 32'h6666_0000 + word_t'(i), m_pc + 32'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
